// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and framing constants for the IMEM loader
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    CSUM,
    FIN
  } state_t;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - little-endian byte-to-word assembler
// word/word_valid are valid in the cycle the last byte of a word is presented.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [IDX_W-1:0] idx;
  logic [23:0]      sh;

  // Only the first three bytes are stored; the fourth is taken straight from data.
  assign word       = {data, sh};
  assign word_valid = en && (idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
      sh  <= '0;
    end else if (clr) begin
      idx <= '0;
      sh  <= '0;
    end else if (en) begin
      idx <= idx + IDX_W'(1);
      sh  <= {data, sh[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream program loader driving the IMEM write port
// Optional trailing-checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [3:0]        imem_wea,
  output logic [ADDR_W-1:0] imem_addra,
  output logic [31:0]       imem_dina,
  output logic [31:0]       PC_rst,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  cnt;
  logic              fire;
  logic              asm_en;
  logic              asm_clr;
  logic [31:0]       word;
  logic              word_valid;

  assign in_ready = (state == ADDR) || (state == LEN) || (state == DATA) || (state == CSUM);
  assign fire     = in_valid && in_ready;
  assign asm_en   = fire && (state != CSUM);
  assign asm_clr  = (state == IDLE) && start;

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .en         (asm_en),
    .data       (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      imem_wea   <= 4'h0;
      imem_addra <= '0;
      imem_dina  <= '0;
      PC_rst     <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      imem_wea <= 4'h0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ADDR;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
            err_q    <= 1'b0;
`endif
          end
        end
        ADDR: begin
          if (word_valid) begin
            PC_rst <= {word[31:2], 2'b00};
            ptr    <= word[ADDR_W+1:2];
            state  <= LEN;
          end
        end
        LEN: begin
          if (word_valid) begin
            cnt <= word[LEN_W-1:0];
            if (word[LEN_W-1:0] == '0) begin
              state    <= FIN;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (fire) csum <= csum ^ in_data;
`endif
          // The write cycle overlaps the next byte, so streaming never stalls.
          if (word_valid) begin
            imem_wea   <= 4'hF;
            imem_addra <= ptr;
            imem_dina  <= word;
            ptr        <= ptr + ADDR_W'(1);
            cnt        <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= CSUM;
`else
              state    <= FIN;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
`endif
            end
          end
        end
        CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          // A mismatch still releases the core; software decides what to do with err.
          if (fire) begin
            err_q    <= (in_data != csum);
            state    <= FIN;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end
`else
          state <= IDLE;
`endif
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
// Build with +define+IMEM_LOADER_CHECKSUM_EN to exercise the trailing checksum byte.
module tb_imem_loader;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic [3:0]    imem_wea;
  logic [AW-1:0] imem_addra;
  logic [31:0]   imem_dina;
  logic [31:0]   PC_rst;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          gaps = 1'b0;
  logic [31:0] pay[$];
  logic [45:0] wr_q[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_wea   (imem_wea),
    .imem_addra (imem_addra),
    .imem_dina  (imem_dina),
    .PC_rst     (PC_rst),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_wea != 4'h0) begin
      wr_q.push_back({imem_addra, imem_dina});
      chk("wea_all_lanes", imem_wea, 4'hF);
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wea"}, imem_wea, 0);
    chk({tag, "_addra"}, imem_addra, 0);
    chk({tag, "_dina"}, imem_dina, 0);
    chk({tag, "_pc_rst"}, PC_rst, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned last);
    int n = 0;
    @(negedge clk);
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_latency", cyc - last, 0);
      chk("busy_at_done", busy, 0);
      chk("hold_at_done", cpu_hold, 0);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_not_ready", in_ready, 0);
  endtask

  // Reference: word i of the payload lands at ((addr/4)+i) mod 2^AW.
  task automatic check_writes(input logic [31:0] addr, input int nexp);
    logic [AW-1:0] ea;
    chk("wr_count", wr_q.size(), nexp);
    for (int i = 0; i < nexp && i < wr_q.size(); i++) begin
      ea = AW'((addr >> 2) + i);
      chk("wr_addr", wr_q[i][45:32], ea);
      chk("wr_data", wr_q[i][31:0], pay[i]);
    end
  endtask

  task automatic run_session(input logic [31:0] addr, input bit poke, input bit bad_csum);
    logic [7:0] x = 8'h00;
    wr_q.delete();
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("hold_after_start", cpu_hold, 1);
    chk("err_after_start", err, 0);
    send_word(addr);
    send_word(32'(pay.size()));
    for (int i = 0; i < pay.size(); i++) begin
      send_word(pay[i]);
      x = x ^ pay[i][7:0] ^ pay[i][15:8] ^ pay[i][23:16] ^ pay[i][31:24];
      if (poke && i == 0) pulse_start();
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (pay.size() > 0) send_byte(x ^ {7'b0, bad_csum});
`endif
    wait_done(cyc);
    check_writes(addr, pay.size());
    chk("pc_rst", PC_rst, addr & 32'hFFFF_FFFC);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("err_result", err, (pay.size() > 0) ? bad_csum : 1'b0);
`else
    chk("err_result", err, 0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    pay = '{32'h0000_0513, 32'h0010_0593};
    run_session(32'h0000_1000, 1'b0, 1'b0);

    pay.delete();
    run_session(32'h0000_0000, 1'b0, 1'b0);

    gaps = 1'b1;
    pay = '{$urandom, $urandom};
    run_session(32'h0000_FFFC, 1'b0, 1'b0);
    gaps = 1'b0;

    pay = '{$urandom, $urandom};
    wr_q.delete();
    pulse_start();
    send_word(32'h0000_2000);
    send_word(32'd2);
    send_word(pay[0]);
    send_byte(pay[1][7:0]);
    send_byte(pay[1][15:8]);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk_quiet("mid_reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_writes(32'h0000_2000, 1);

    pay = '{$urandom, $urandom, $urandom};
    run_session(32'h0000_0040, 1'b0, 1'b0);

    pay = '{$urandom, $urandom};
    run_session(32'h0000_0102, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pay = '{32'hFF00_55AA};
    run_session(32'h0000_0800, 1'b0, 1'b0);
    run_session(32'h0000_0800, 1'b0, 1'b1);
`endif

    for (int r = 0; r < 6; r++) begin
      int n;
      logic [31:0] a;
      n    = $urandom_range(0, 4);
      a    = $urandom;
      gaps = ($urandom_range(0, 1) == 1);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back($urandom);
      run_session(a, 1'b0, ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
